// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word, RAM status and arbiter grant state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter, grouped as one bus.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  // Arbiter view.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Environment view: caches plus RAM model.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of data wins while the icache waits; clear beats increment.
module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat = (cnt_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Grants the single RAM port to the dcache or icache for one whole transaction;
// dcache wins unless the icache has been starved STARVE_LIMIT times.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  arb_state_t state_q;
  arb_state_t state_d;

  logic  d_req;
  logic  r_access;
  logic  starve_inc;
  logic  starve_clr;
  logic  starve_sat;

  logic  ram_ren;
  logic  ram_wen;
  word_t ram_addr;
  word_t ram_store;
  logic  i_wait;
  logic  d_wait;
  word_t i_load;
  word_t d_load;

  assign d_req    = bus.dREN | bus.dWEN;
  assign r_access = (bus.ramstate == ACCESS);

  // An aborted data request does not count as a completion.
  assign starve_inc = (state_q == DSERV) && d_req && r_access && bus.iREN;
  assign starve_clr = ((state_q == ISERV) && r_access) ||
                      ((state_q == IDLE) && !bus.iREN);

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve_ctr (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (starve_inc),
    .clr  (starve_clr),
    .sat  (starve_sat)
  );

  always_comb begin
    state_d   = state_q;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    i_wait    = 1'b1;
    d_wait    = 1'b1;
    i_load    = '0;
    d_load    = '0;

    case (state_q)
      IDLE: begin
        if (d_req && !(bus.iREN && starve_sat)) begin
          state_d = DSERV;
        end else if (bus.iREN) begin
          state_d = ISERV;
        end
      end

      DSERV: begin
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        d_load    = bus.ramload;
        ram_wen   = bus.dWEN;
        ram_ren   = bus.dREN && !bus.dWEN;
        if (!d_req) begin
          state_d = IDLE;
        end else if (r_access) begin
          d_wait  = 1'b0;
          state_d = IDLE;
        end
      end

      ISERV: begin
        ram_ren  = 1'b1;
        ram_addr = bus.iaddr;
        i_load   = bus.ramload;
        i_wait   = !r_access;
        if (r_access || !bus.iREN) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iwait    = i_wait;
  assign bus.dwait    = d_wait;
  assign bus.iload    = i_load;
  assign bus.dload    = d_load;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level owner/starvation model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns RAM (0 nobody, 1 dcache, 2 icache) and data wins seen.
  int owner = 0;
  int starve = 0;

  logic obs_iwait;
  logic obs_dwait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks mid-cycle, advances model.
  task automatic step(input logic ir, input logic dr, input logic dw,
                      input word_t ia, input word_t da, input word_t ds,
                      input word_t rl, input ramstate_t rs);
    logic  e_ren, e_wen, e_iw, e_dw;
    word_t e_addr, e_store, e_il, e_dl;
    int    n_owner, n_starve;
    logic  dreq, done;

    bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
    bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
    bus.ramload = rl; bus.ramstate = rs;
    #4;

    dreq = dr | dw;
    done = (rs == ACCESS);
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
    e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
    n_owner = owner; n_starve = starve;

    if (owner == 1) begin
      e_addr = da; e_store = ds; e_dl = rl;
      if (dreq) begin
        e_wen = dw;
        e_ren = !dw;
        e_dw  = !done;
      end
      if (!dreq) n_owner = 0;
      else if (done) begin
        n_owner = 0;
        if (ir) n_starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
      end
    end else if (owner == 2) begin
      e_ren = 1; e_addr = ia; e_il = rl; e_iw = !done;
      if (done) begin
        n_owner = 0;
        n_starve = 0;
      end else if (!ir) n_owner = 0;
    end else begin
      if (dreq && !(ir && starve == LIMIT)) n_owner = 1;
      else if (ir) n_owner = 2;
      if (!ir) n_starve = 0;
    end

    obs_iwait = bus.iwait;
    obs_dwait = bus.dwait;
    chk("ramREN",   32'(bus.ramREN), 32'(e_ren));
    chk("ramWEN",   32'(bus.ramWEN), 32'(e_wen));
    chk("ramaddr",  bus.ramaddr,     e_addr);
    chk("ramstore", bus.ramstore,    e_store);
    chk("iwait",    32'(bus.iwait),  32'(e_iw));
    chk("dwait",    32'(bus.dwait),  32'(e_dw));
    chk("iload",    bus.iload,       e_il);
    chk("dload",    bus.dload,       e_dl);

    @(posedge CLK);
    owner = n_owner;
    starve = n_starve;
    #1;
  endtask

  // Asserts reset mid-cycle, checks the reset outputs, releases after an edge.
  task automatic do_reset();
    nRST = 1'b1;
    #2;
    chk("rst_ramREN",   32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN",   32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr",  bus.ramaddr,     32'd0);
    chk("rst_ramstore", bus.ramstore,    32'd0);
    chk("rst_iwait",    32'(bus.iwait),  32'd1);
    chk("rst_dwait",    32'(bus.dwait),  32'd1);
    chk("rst_iload",    bus.iload,       32'd0);
    chk("rst_dload",    bus.dload,       32'd0);
    owner = 0;
    starve = 0;
    @(posedge CLK);
    #1;
    nRST = 1'b0;
  endtask

  initial begin
    int d_done, guard;
    logic i_seen;

    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0;
    bus.ramload = 0; bus.ramstate = FREE;
    do_reset();

    // Lone icache read: BUSY, BUSY, ACCESS.
    step(1, 0, 0, 32'h40, 0, 0, 0, FREE);
    step(1, 0, 0, 32'h40, 0, 0, 32'h1111_1111, BUSY);
    step(1, 0, 0, 32'h40, 0, 0, 32'h2222_2222, BUSY);
    step(1, 0, 0, 32'h40, 0, 0, 32'h8C01_0004, ACCESS);
    step(0, 0, 0, 0, 0, 0, 0, FREE);

    // Write has priority over read.
    step(0, 1, 1, 0, 32'h100, 32'hDEAD_BEEF, 0, FREE);
    step(0, 1, 1, 0, 32'h100, 32'hDEAD_BEEF, 0, BUSY);
    step(0, 1, 1, 0, 32'h100, 32'hDEAD_BEEF, 0, ACCESS);
    step(0, 0, 0, 0, 0, 0, 0, FREE);

    // Simultaneous requests: data first, then instruction after the bubble.
    step(1, 1, 0, 32'h80, 32'h200, 0, 0, FREE);
    step(1, 1, 0, 32'h80, 32'h200, 0, 32'hAAAA_0001, ACCESS);
    step(1, 0, 0, 32'h80, 0, 0, 0, FREE);
    step(1, 0, 0, 32'h80, 0, 0, 32'hBBBB_0002, ACCESS);
    step(0, 0, 0, 0, 0, 0, 0, FREE);

    // Starvation: iREN and dREN held, RAM answers at once.
    d_done = 0;
    i_seen = 0;
    guard = 0;
    while (!i_seen && guard < 40) begin
      step(1, 1, 0, 32'hC0, 32'h300, 0, 32'h5A5A_0000 + 32'(guard), ACCESS);
      if (!obs_iwait) i_seen = 1;
      else if (!obs_dwait) d_done++;
      guard++;
    end
    chk("starve_i_granted", 32'(i_seen), 32'd1);
    chk("starve_d_wins", 32'(d_done), 32'(LIMIT));
    // Counter cleared: the next contest goes to the dcache again.
    step(1, 1, 0, 32'hC0, 32'h300, 0, 32'h1234_5678, ACCESS);
    chk("starve_cleared_dwin", 32'(obs_dwait), 32'd1);
    step(1, 1, 0, 32'hC0, 32'h300, 0, 32'h1234_5678, ACCESS);
    chk("starve_cleared_dwin2", 32'(obs_dwait), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, FREE);

    // Abort during BUSY.
    step(0, 1, 0, 0, 32'h400, 0, 0, FREE);
    step(0, 1, 0, 0, 32'h400, 0, 0, BUSY);
    step(0, 0, 0, 0, 32'h400, 0, 0, BUSY);
    step(0, 0, 0, 0, 0, 0, 0, BUSY);

    // ERROR for three cycles, then ACCESS.
    step(0, 1, 0, 0, 32'h500, 0, 0, FREE);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 32'h500, 0, 32'hEEEE_0000, ERROR);
    step(0, 1, 0, 0, 32'h500, 0, 32'hCAFE_F00D, ACCESS);
    step(0, 0, 0, 0, 0, 0, 0, FREE);

    // Reset in the middle of a data transaction.
    step(1, 1, 0, 32'h40, 32'h600, 0, 0, FREE);
    step(1, 1, 0, 32'h40, 32'h600, 0, 0, BUSY);
    do_reset();
    step(1, 1, 0, 32'h40, 32'h600, 0, 0, BUSY);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic ir, dr, dw;
      ramstate_t rs;
      int r;
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        ir = ($urandom_range(0, 9) < 7);
        dr = ($urandom_range(0, 9) < 6);
        dw = ($urandom_range(0, 9) < 3);
        r = $urandom_range(0, 9);
        rs = (r < 4) ? ACCESS : (r < 7) ? BUSY : (r < 9) ? FREE : ERROR;
        step(ir, dr, dw, $urandom, $urandom, $urandom, $urandom, rs);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single unified RAM port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the caches and RAM, below fetch and memory stages, so one requester owns RAM per transaction.
- Grant is registered and held for the whole transaction until RAM reports ACCESS.
- The data cache normally has priority; a starvation counter forces an instruction grant after STARVE_LIMIT consecutive data wins while iREN is pending.

Parameters:
STARVE_LIMIT, 4, consecutive completed data transactions tolerated while iREN is pending before the instruction cache is forced to win.
CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-high (asserted = 1).
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; 0 only in the cycle its data is valid.
- iload  out  32  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status, ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Reset (async, any cycle, including mid-transaction):
  - state goes to IDLE and the starvation counter to 0.
  - Outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
  - Any in-flight RAM transaction is abandoned; requesters re-request after reset.
- States, arb_state_t: IDLE, DSERV, ISERV.
- IDLE:
  - No RAM enables; iwait=dwait=1.
  - Next state:
    - DSERV if (dREN|dWEN) and not (iREN and cnt==STARVE_LIMIT).
    - Otherwise ISERV if iREN.
    - Otherwise IDLE.
- DSERV:
  - ramaddr=daddr, ramstore=dstore.
  - dWEN has priority over dREN: if both are high, ramWEN=1 and ramREN=0.
  - dload=ramload; dwait = (ramstate!=ACCESS); iwait=1.
  - On ACCESS, go to IDLE.
  - If dREN=dWEN=0 (abort), go to IDLE with no RAM enables that cycle.
  - ERROR or BUSY: hold the state, hold the enables, keep dwait=1.
- ISERV:
  - ramREN=1, ramaddr=iaddr, iload=ramload; iwait = (ramstate!=ACCESS); dwait=1.
  - On ACCESS, go to IDLE.
  - If iREN drops, go to IDLE.
  - ERROR or BUSY: hold.
- Latency:
  - A request seen in IDLE at edge N drives RAM from cycle N+1.
  - Minimum service time is 2 cycles (grant + ACCESS).
  - One mandatory IDLE bubble between transactions, so no back-to-back grant skipping arbitration.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each DSERV completion (ACCESS) while iREN=1.
  - Clears on ISERV completion, and whenever iREN=0 in IDLE.
- Simultaneous events:
  - iREN and dREN in IDLE with cnt<STARVE_LIMIT: data wins.
  - Same with cnt==STARVE_LIMIT: instruction wins.
- Outputs are combinational from state plus inputs; only state and cnt are registered.
- ramload is passed through unmodified; the non-granted load output is driven to 0.

Decomposition:
- cpu_types_pkg: word_t (32-bit) and ramstate_t already live there; add arb_state_t {IDLE, DSERV, ISERV}.
- One sub-module, arb_starve_ctr: saturating CNT_W counter with inc, clr and sat outputs, parameterised by STARVE_LIMIT.
- mem_arbiter holds the FSM and output muxing.

Test Plan:
- Reset mid-DSERV: assert nRST=1 with ramstate=BUSY. Required: state IDLE the same cycle; ramREN=0, ramWEN=0, dwait=1, cnt=0.
- Lone icache read:
  - Stimulus: iREN=1, iaddr=0x0000_0040; RAM returns BUSY, BUSY, then ACCESS with ramload=0x8C01_0004.
  - Required: ramREN=1, ramaddr=0x40 from cycle 1; iwait=0 and iload=0x8C01_0004 exactly on the ACCESS cycle; IDLE next.
- Write priority:
  - Stimulus: dREN=dWEN=1, daddr=0x100, dstore=0xDEAD_BEEF.
  - Required: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, iwait stays 1.
- Simultaneous requests: iREN and dREN together in IDLE with cnt=0. Required: DSERV first, ISERV after the IDLE bubble.
- Starvation:
  - Stimulus: iREN held; dREN re-asserted continuously; STARVE_LIMIT=4.
  - Required: 4 DSERV completions, then ISERV granted even though dREN=1; cnt returns to 0 after the i ACCESS.
- Abort and error: dREN drops during DSERV BUSY, or ramstate=ERROR for 3 cycles. Required:
  - Abort: IDLE next cycle, no enables.
  - ERROR: state holds, dwait=1, completion on the later ACCESS.
